spike_out_packer: RTL and testbench
===================================

Name: spike_out_packer

Overview:
- Downstream stage of the compute unit.
- Consumes the NUM_PES-wide output spike vector produced once per timestep for each output channel.
- Accumulates per-PE spike counts over the programmed number of timesteps (rate coding) and packs one record per output channel into an internal FIFO.
- Presents records to the output memory writer over a valid/ready interface; pulses done when the whole layer has been drained.

Parameters:
- NUM_PES, 9, spike lanes per vector (matches the compute unit PE count).
- FIFO_DEPTH, 8, record FIFO depth; must be a power of 2, ≥2.
- CNT_W, 5, per-lane count width; holds 0..16.

Ports:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- start  in  1  one-cycle pulse; latches configuration and begins a layer (honoured only in IDLE)
- num_timesteps  in  4  timesteps per channel; 0 encodes 16
- c_out  in  4  output channels per layer; 0 encodes 16
- spk_valid  in  1  spike vector valid
- spk_data  in  NUM_PES  spike vector, bit i = PE i fired
- spk_ready  out  1  packer accepts the vector this cycle
- out_valid  out  1  record available
- out_ready  in  1  consumer takes the record
- out_data  out  NUM_PES*CNT_W+4  {chan[3:0], cnt[NUM_PES-1]..cnt[0]}
- out_last  out  1  record is the last channel of the layer
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the layer is fully drained

Behaviour:
- Reset (nrst low, async):
  - State IDLE; all counters, FIFO pointers and occupancy cleared.
  - Outputs: spk_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - Reset mid-layer discards all partial counts and queued records.
- State IDLE:
  - spk_ready=0.
  - start=1 latches ts_max and ch_max (0 mapped to 16), clears ts_cnt, ch_cnt and lane counts, then goes to ACCUM.
- State ACCUM:
  - spk_ready = !fifo_full, using registered occupancy; there is no combinational path from out_ready to spk_ready.
  - Accept = spk_valid && spk_ready. On each accept, cnt[i] += spk_data[i] for every lane.
  - Non-final timestep accept: ts_cnt++.
  - Final timestep accept (ts_cnt == ts_max-1):
    - Push record {ch_cnt, cnt+spk_data} into the FIFO.
    - Clear the counts and ts_cnt.
    - ch_cnt++.
    - The pushed record's out_last = (ch_cnt == ch_max-1).
    - If it was the last channel, go to DRAIN.
  - start is ignored while in ACCUM.
- State DRAIN:
  - spk_ready=0.
  - When the FIFO is empty (after the final pop), pulse done for one cycle and return to IDLE.
- FIFO:
  - Registered output with no fall-through. A record pushed at edge k gives out_valid=1 in the cycle after edge k.
  - Pop = out_valid && out_ready. The next record appears in the following cycle when present; back-to-back pops therefore sustain one record per cycle.
  - Simultaneous push and pop: occupancy is unchanged and both take effect.
  - Full: no push is possible because spk_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Protocol:
  - out_data and out_last stay stable while out_valid=1 && out_ready=0.
  - spk_data is sampled only on accept.
- Arithmetic: counts saturate at 16 by construction (at most 16 timesteps); CNT_W=5 is sufficient.

Test Plan:
- Basic layer: reset, start with num_timesteps=4, c_out=2, NUM_PES=9; send 8 vectors with lane 0 always 1 and lane 8 1 on even timesteps only; out_ready=1.
  -> Two records: chan 0 then chan 1, each with cnt0=4, cnt8=2, other lanes 0.
  -> out_last=1 only on chan 1; done pulses once after the second pop; busy falls in the same cycle done rises.
- Back-pressure: FIFO_DEPTH=8, num_timesteps=1, c_out=0 (16 channels), out_ready=0.
  -> spk_ready drops after 8 accepts; no records are lost.
  -> Raising out_ready drains records in chan order 0..15, with out_data held stable while stalled.
- Encoded maximums: num_timesteps=0, all-ones spk_data for 16 vectors.
  -> A single record per channel with every cnt=16.
- Mid-layer reset: assert nrst low after 3 accepts of a 4-timestep channel.
  -> All outputs return to reset values.
  -> After a new start, the first record's counts exclude the pre-reset vectors.
- Start and spike noise: pulse start during ACCUM, and drive spk_valid=1 in IDLE.
  -> Configuration is unchanged; no vectors are accepted in IDLE (spk_ready=0).
  -> Record count equals c_out.
- Simultaneous push/pop: FIFO holding 1 record, out_ready=1, final-timestep accept in the same cycle.
  -> Occupancy stays 1 and the next record is presented the following cycle.

Source files
------------

// File: rtl/spike_out_packer_if.sv
// Handshake bundle between the compute unit, the spike packer and the output memory writer.
// The slave modport is the packer's view. The master modport is the surrounding environment's view.
interface spike_out_packer_if #(
   parameter int unsigned NUM_PES = 9,
   parameter int unsigned CNT_W   = 5
);
   logic                         spk_valid;
   logic [NUM_PES-1:0]           spk_data;
   logic                         spk_ready;
   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_PES*CNT_W+3:0]     out_data;
   logic                         out_last;

   modport master (
      output spk_valid, spk_data, out_ready,
      input  spk_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  spk_valid, spk_data, out_ready,
      output spk_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/spike_out_packer.sv
// Rate-codes per-PE spike counts over a programmed number of timesteps.
// Queues one {chan, counts} record per output channel for the memory writer.
module spike_out_packer #(
   parameter int unsigned NUM_PES    = 9,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 5
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     i_start,
   input  logic [3:0]               i_num_timesteps,
   input  logic [3:0]               i_c_out,
   spike_out_packer_if.slave        bus,
   output logic                     o_busy,
   output logic                     o_done
);
   localparam int unsigned REC_W = NUM_PES*CNT_W + 4;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t                         r_state, w_next;
   logic [4:0]                     r_ts_max, r_ch_max, r_ts_cnt, r_ch_cnt;
   logic [NUM_PES-1:0][CNT_W-1:0]  r_cnt, w_cnt_sum;
   logic [REC_W:0]                 r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]               r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]                 r_count;
   logic                           r_done;
   logic                           w_accept, w_final_ts, w_last_ch, w_push, w_pop;

   always_comb begin
      for (int unsigned i = 0; i < NUM_PES; i++) begin
         w_cnt_sum[i] = r_cnt[i] + CNT_W'(bus.spk_data[i]);
      end
   end

   assign bus.spk_ready = (r_state == ACCUM) && (r_count != FULL_CNT);
   assign w_accept      = bus.spk_valid && bus.spk_ready;
   assign w_final_ts    = (r_ts_cnt == r_ts_max - 5'd1);
   assign w_last_ch     = (r_ch_cnt == r_ch_max - 5'd1);
   assign w_push        = w_accept && w_final_ts;
   assign w_pop         = bus.out_valid && bus.out_ready;

   // The head entry is read straight from storage, so nothing is presented until the cycle after the push.
   assign bus.out_valid = (r_count != '0);
   assign {bus.out_last, bus.out_data} = r_mem[r_rd_ptr];
   assign o_busy        = (r_state != IDLE);
   assign o_done        = r_done;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (i_start) w_next = ACCUM;
         ACCUM:   if (w_push && w_last_ch) w_next = DRAIN;
         DRAIN:   if (r_count == '0) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_ts_max <= '0;
         r_ch_max <= '0;
         r_ts_cnt <= '0;
         r_ch_cnt <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == DRAIN) && (r_count == '0);
         if (r_state == IDLE && i_start) begin
            // A zero field encodes 16, which sets bit 4 and leaves the low bits clear.
            r_ts_max <= {i_num_timesteps == 4'd0, i_num_timesteps};
            r_ch_max <= {i_c_out == 4'd0, i_c_out};
            r_ts_cnt <= '0;
            r_ch_cnt <= '0;
            r_cnt    <= '0;
         end else if (w_accept) begin
            if (w_final_ts) begin
               r_cnt    <= '0;
               r_ts_cnt <= '0;
               r_ch_cnt <= r_ch_cnt + 5'd1;
            end else begin
               r_cnt    <= w_cnt_sum;
               r_ts_cnt <= r_ts_cnt + 5'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last_ch, r_ch_cnt[3:0], w_cnt_sum};
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_spike_out_packer.sv
// Directed bench for spike_out_packer: record contents, back-pressure, encoded maximums, reset and noise.
module tb_spike_out_packer;
   logic       clk;
   logic       nrst;
   logic       start;
   logic [3:0] num_timesteps;
   logic [3:0] c_out;
   logic       busy;
   logic       done;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned done_cnt = 0;
   int unsigned acc_cnt  = 0;
   logic [49:0] rec_q[$];

   spike_out_packer_if #(.NUM_PES(9), .CNT_W(5)) bus ();

   spike_out_packer #(.NUM_PES(9), .FIFO_DEPTH(8), .CNT_W(5)) dut (
      .clk             (clk),
      .nrst            (nrst),
      .i_start         (start),
      .i_num_timesteps (num_timesteps),
      .i_c_out         (c_out),
      .bus             (bus),
      .o_busy          (busy),
      .o_done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sampled mid-cycle, after the negedge drive and before the next active edge.
   always @(negedge clk) begin
      #2;
      if (bus.out_valid && bus.out_ready) rec_q.push_back({bus.out_last, bus.out_data});
      if (bus.spk_valid && bus.spk_ready) acc_cnt++;
      if (done) begin
         done_cnt++;
         check("busy_at_done", 64'(busy), 64'(0));
      end
   end

   function automatic logic [49:0] mk_rec(input logic last, input logic [3:0] ch,
                                          input logic [8:0] lane_mask, input int unsigned val);
      logic [49:0] r;
      r = '0;
      r[49] = last;
      r[48:45] = ch;
      for (int i = 0; i < 9; i++) if (lane_mask[i]) r[5*i +: 5] = 5'(val);
      return r;
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_spk_ready"}, 64'(bus.spk_ready), 64'(0));
      check({pfx, "_out_valid"}, 64'(bus.out_valid), 64'(0));
      check({pfx, "_out_data"},  64'(bus.out_data),  64'(0));
      check({pfx, "_out_last"},  64'(bus.out_last),  64'(0));
      check({pfx, "_busy"},      64'(busy),          64'(0));
      check({pfx, "_done"},      64'(done),          64'(0));
   endtask

   task automatic start_layer(input logic [3:0] ts, input logic [3:0] co);
      @(negedge clk);
      num_timesteps = ts;
      c_out = co;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_vec(input logic [8:0] d);
      int unsigned k;
      k = 0;
      bus.spk_valid = 1'b1;
      bus.spk_data  = d;
      #2;
      while (!bus.spk_ready && k < 300) begin
         @(negedge clk);
         #2;
         k++;
      end
      if (k >= 300) check("send_timeout", 64'(1), 64'(0));
      @(negedge clk);
      bus.spk_valid = 1'b0;
   endtask

   task automatic wait_done(input int unsigned base);
      int unsigned k;
      k = 0;
      while (done_cnt == base && k < 500) begin
         @(negedge clk);
         k++;
      end
      if (k >= 500) check("done_timeout", 64'(1), 64'(0));
      repeat (3) @(negedge clk);
      check("done_once", 64'(done_cnt), 64'(base + 1));
   endtask

   initial begin
      int unsigned base;
      nrst = 1'b0;
      start = 1'b0;
      num_timesteps = '0;
      c_out = '0;
      bus.spk_valid = 1'b0;
      bus.spk_data = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check_reset_outputs("rst");
      @(negedge clk);
      nrst = 1'b1;

      // Basic layer: 4 timesteps, 2 channels
      bus.out_ready = 1'b1;
      rec_q.delete();
      base = done_cnt;
      start_layer(4'd4, 4'd2);
      check("busy_accum", 64'(busy), 64'(1));
      for (int c = 0; c < 2; c++)
         for (int t = 0; t < 4; t++) send_vec((t % 2 == 0) ? 9'h101 : 9'h001);
      wait_done(base);
      check("basic_count", 64'(rec_q.size()), 64'(2));
      if (rec_q.size() == 2) begin
         check("basic_rec0", 64'(rec_q[0]),
               64'(mk_rec(1'b0, 4'd0, 9'h001, 4) | mk_rec(1'b0, 4'd0, 9'h100, 2)));
         check("basic_rec1", 64'(rec_q[1]),
               64'(mk_rec(1'b1, 4'd1, 9'h001, 4) | mk_rec(1'b1, 4'd1, 9'h100, 2)));
      end

      // Back-pressure: 1 timestep, 16 channels, consumer stalled
      bus.out_ready = 1'b0;
      rec_q.delete();
      base = done_cnt;
      start_layer(4'd1, 4'd0);
      for (int c = 0; c < 8; c++) send_vec(9'h100 | 9'(c));
      #2;
      check("bp_ready_low", 64'(bus.spk_ready), 64'(0));
      for (int k = 0; k < 3; k++) begin
         check("bp_valid_held", 64'(bus.out_valid), 64'(1));
         check("bp_data_held", 64'({bus.out_last, bus.out_data}), 64'(mk_rec(1'b0, 4'd0, 9'h100, 1)));
         @(negedge clk);
         #2;
      end
      check("bp_ready_still_low", 64'(bus.spk_ready), 64'(0));
      @(negedge clk);
      bus.out_ready = 1'b1;
      for (int c = 8; c < 16; c++) send_vec(9'h100 | 9'(c));
      wait_done(base);
      check("bp_count", 64'(rec_q.size()), 64'(16));
      if (rec_q.size() == 16)
         for (int c = 0; c < 16; c++) begin
            logic [8:0] m;
            m = 9'h100 | 9'(c);
            check($sformatf("bp_rec%0d", c), 64'(rec_q[c]), 64'(mk_rec(c == 15, 4'(c), m, 1)));
         end

      // Encoded maximum: 16 timesteps, all lanes fire every time
      rec_q.delete();
      base = done_cnt;
      start_layer(4'd0, 4'd2);
      for (int t = 0; t < 32; t++) send_vec(9'h1FF);
      wait_done(base);
      check("max_count", 64'(rec_q.size()), 64'(2));
      if (rec_q.size() == 2) begin
         check("max_rec0", 64'(rec_q[0]), 64'(mk_rec(1'b0, 4'd0, 9'h1FF, 16)));
         check("max_rec1", 64'(rec_q[1]), 64'(mk_rec(1'b1, 4'd1, 9'h1FF, 16)));
      end

      // Mid-layer reset after 3 of 4 timesteps
      rec_q.delete();
      start_layer(4'd4, 4'd1);
      for (int t = 0; t < 3; t++) send_vec(9'h1FF);
      nrst = 1'b0;
      #2;
      check_reset_outputs("midrst");
      @(negedge clk);
      nrst = 1'b1;
      base = done_cnt;
      start_layer(4'd4, 4'd1);
      for (int t = 0; t < 4; t++) send_vec(9'h003);
      wait_done(base);
      check("midrst_count", 64'(rec_q.size()), 64'(1));
      if (rec_q.size() == 1)
         check("midrst_rec", 64'(rec_q[0]), 64'(mk_rec(1'b1, 4'd0, 9'h003, 4)));

      // Noise: spikes in IDLE, start pulse during ACCUM
      rec_q.delete();
      base = acc_cnt;
      @(negedge clk);
      bus.spk_valid = 1'b1;
      bus.spk_data = 9'h1FF;
      repeat (5) begin
         #2;
         check("idle_spk_ready", 64'(bus.spk_ready), 64'(0));
         @(negedge clk);
      end
      bus.spk_valid = 1'b0;
      check("idle_no_accept", 64'(acc_cnt), 64'(base));
      base = done_cnt;
      start_layer(4'd2, 4'd3);
      send_vec(9'h010);
      start_layer(4'd1, 4'd1);
      for (int t = 0; t < 5; t++) send_vec(9'h010);
      wait_done(base);
      check("noise_count", 64'(rec_q.size()), 64'(3));
      if (rec_q.size() == 3)
         check("noise_rec2", 64'(rec_q[2]), 64'(mk_rec(1'b1, 4'd2, 9'h010, 2)));

      // Simultaneous push and pop with one record queued
      rec_q.delete();
      bus.out_ready = 1'b0;
      base = done_cnt;
      start_layer(4'd1, 4'd3);
      send_vec(9'h001);
      bus.out_ready = 1'b1;
      bus.spk_valid = 1'b1;
      bus.spk_data = 9'h002;
      #2;
      check("pp_accept", 64'(bus.spk_ready), 64'(1));
      @(negedge clk);
      bus.spk_valid = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      check("pp_valid", 64'(bus.out_valid), 64'(1));
      check("pp_next_rec", 64'({bus.out_last, bus.out_data}), 64'(mk_rec(1'b0, 4'd1, 9'h002, 1)));
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #2;
      check("pp_occ_one", 64'(bus.out_valid), 64'(0));
      bus.out_ready = 1'b1;
      send_vec(9'h004);
      wait_done(base);
      check("pp_count", 64'(rec_q.size()), 64'(3));
      if (rec_q.size() == 3)
         check("pp_rec2", 64'(rec_q[2]), 64'(mk_rec(1'b1, 4'd2, 9'h004, 1)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end
endmodule
